// File: rtl/apb_pad_scanner_if.sv
// APB3 bus bundle for apb_pad_scanner.
// master: PSEL/PENABLE/PWRITE/PADDR/PWDATA out; slave: PRDATA/PREADY/PSLVERR out.
interface apb_pad_scanner_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_pad_scanner.sv
// APB3 slave scanning NUM_PADS serial shift-register gamepads in parallel.
// Ports: PCLK, PRESERN (async low), apb (slave), pad_latch, pad_clk,
// pad_data[NUM_PADS], irq. Optional macro CHANGE_IRQ_EN adds per-pad
// change flags (STATUS[11:8]) and drives irq from them instead of done.
module apb_pad_scanner #(
    parameter int NUM_PADS    = 2,
    parameter int NUM_BITS    = 12,
    parameter int CLK_DIV     = 4,
    parameter int POLL_PERIOD = 50000
) (
    input  logic                PCLK,
    input  logic                PRESERN,
    apb_pad_scanner_if.slave    apb,
    output logic                pad_latch,
    output logic                pad_clk,
    input  logic [NUM_PADS-1:0] pad_data,
    output logic                irq
);
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [CW-1:0] LATCH_LEN = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LEN  = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(NUM_BITS - 1);
    localparam logic [PW-1:0] RELOAD    = PW'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_SHIFT_LO, S_SHIFT_HI, S_DONE
    } state_t;

    typedef logic [NUM_PADS-1:0][NUM_BITS-1:0] words_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [PW-1:0]        period_q, period_d;
    logic [NUM_PADS-1:0]  sync1_q, sync2_q;
    logic                 auto_en_q, auto_en_d;
    logic                 irq_en_q, irq_en_d;
    logic                 done_q, done_d;
    logic [15:0]          scan_cnt_q, scan_cnt_d;
    words_t               shadow_q, shadow_d;
    words_t               pad_q, pad_d;
    logic                 pad_latch_q, pad_latch_d;
    logic                 pad_clk_q, pad_clk_d;
    logic                 irq_q, irq_d;
    logic [NUM_PADS-1:0]  changed_q, changed_d;

    logic        access, wr, start, busy;
    logic [5:0]  addr;
    logic        sel_ctrl, sel_stat, sel_cnt, sel_pad, mapped;
    logic [31:0] pad_word, rdata;
    logic [3:0]  chg4;

    always_comb begin
        access = apb.PSEL & apb.PENABLE;
        wr     = access & apb.PWRITE;
        addr   = apb.PADDR[7:2];
        busy   = (state_q != S_IDLE);

        sel_ctrl = (addr == 6'd0);
        sel_stat = (addr == 6'd1);
        sel_cnt  = (addr == 6'd2);
        sel_pad  = 1'b0;
        pad_word = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (addr == 6'(4 + i)) begin
                sel_pad  = 1'b1;
                pad_word = 32'(pad_q[i]);
            end
        end
        mapped = sel_ctrl | sel_stat | sel_cnt | sel_pad;

`ifdef CHANGE_IRQ_EN
        chg4 = 4'(changed_q);
`else
        chg4 = 4'b0;
`endif

        rdata = '0;
        if (access) begin
            unique case (1'b1)
                sel_ctrl: rdata = {30'b0, irq_en_q, auto_en_q};
                sel_stat: rdata = {20'b0, chg4, 6'b0, done_q, busy};
                sel_cnt:  rdata = {16'b0, scan_cnt_q};
                sel_pad:  rdata = pad_word;
                default:  rdata = '0;
            endcase
        end

        auto_en_d   = auto_en_q;
        irq_en_d    = irq_en_q;
        done_d      = done_q;
        changed_d   = changed_q;
        scan_cnt_d  = scan_cnt_q;
        shadow_d    = shadow_q;
        pad_d       = pad_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        period_d    = period_q;

        if (wr && sel_ctrl) begin
            auto_en_d = apb.PWDATA[0];
            irq_en_d  = apb.PWDATA[1];
        end
        if (wr && sel_stat) begin
            if (apb.PWDATA[1]) done_d = 1'b0;
            changed_d = changed_q & ~apb.PWDATA[8 +: NUM_PADS];
        end

        // An expiry while busy leaves the counter parked at 0, so the
        // scan starts on the first IDLE cycle after DONE.
        start = !busy && ((wr && sel_ctrl && apb.PWDATA[2])
                       || (auto_en_q && period_q == '0));

        if (start)
            period_d = RELOAD;
        else if (!auto_en_q)
            period_d = '0;
        else if (period_q != '0)
            period_d = period_q - 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LATCH;
                    cnt_d   = LATCH_LEN;
                    bit_d   = '0;
                end
            end
            S_LATCH: begin
                if (cnt_q == '0) begin
                    state_d = S_SHIFT_LO;
                    cnt_d   = HALF_LEN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SHIFT_LO: begin
                if (cnt_q == '0) begin
                    for (int i = 0; i < NUM_PADS; i++)
                        shadow_d[i][bit_q] = ~sync2_q[i];
                    state_d = S_SHIFT_HI;
                    cnt_d   = HALF_LEN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (cnt_q == '0) begin
                    cnt_d = HALF_LEN;
                    if (bit_q == LAST_BIT) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT_LO;
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                pad_d      = shadow_q;
                done_d     = 1'b1;
                scan_cnt_d = scan_cnt_q + 16'd1;
                for (int i = 0; i < NUM_PADS; i++)
                    if (shadow_q[i] != pad_q[i]) changed_d[i] = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        pad_latch_d = (state_d == S_LATCH);
        pad_clk_d   = (state_d != S_SHIFT_LO);

`ifdef CHANGE_IRQ_EN
        irq_d = irq_en_q & |changed_q;
`else
        irq_d = irq_en_q & done_q;
`endif
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            period_q    <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            auto_en_q   <= 1'b0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            changed_q   <= '0;
            scan_cnt_q  <= '0;
            shadow_q    <= '0;
            pad_q       <= '0;
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b1;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            period_q    <= period_d;
            sync1_q     <= pad_data;
            sync2_q     <= sync1_q;
            auto_en_q   <= auto_en_d;
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
`ifdef CHANGE_IRQ_EN
            changed_q   <= changed_d;
`else
            changed_q   <= '0;
`endif
            scan_cnt_q  <= scan_cnt_d;
            shadow_q    <= shadow_d;
            pad_q       <= pad_d;
            pad_latch_q <= pad_latch_d;
            pad_clk_q   <= pad_clk_d;
            irq_q       <= irq_d;
        end
    end

    assign apb.PRDATA  = rdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = access & ~mapped;
    assign pad_latch   = pad_latch_q;
    assign pad_clk     = pad_clk_q;
    assign irq         = irq_q;

    logic unused_bits;
    assign unused_bits = ^{apb.PWDATA, apb.PADDR[1:0], changed_d};
endmodule
